// File: rtl/dm_agu_pkg.sv
// Shared definitions for the data-memory address generation unit:
// opcode encodings used by the decoder in dm_agu.
package dm_agu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    kLDM  = 3'd0,
    kSTR  = 3'd1,
    kLDP  = 3'd2,
    kSTP  = 3'd3,
    kSETP = 3'd4
  } op_t;

endpackage

// File: rtl/dm_agu_ptr_file.sv
// Pointer register file for dm_agu: NPTR x AW, one write port, one
// combinational read port; a write lands on the edge, so the next read sees it.
module dm_ptr_file #(
  parameter int AW      = 8,
  parameter int NPTR    = 4,
  parameter int PTR_RST = 0,
  localparam int IW     = $clog2(NPTR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic [AW-1:0] i_wdata,
  input  logic [IW-1:0] i_ridx,
  output logic [AW-1:0] o_rdata
);

  localparam logic [AW-1:0] LP_RST = AW'(PTR_RST);

  logic [AW-1:0] r_ptr [NPTR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPTR; i++) r_ptr[i] <= LP_RST;
    end else if (i_we) begin
      r_ptr[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_ptr[i_ridx];

endmodule

// File: rtl/dm_agu.sv
// Data-memory address generation unit with a single-entry output register.
// Optional bounds checking against LIMIT is enabled by defining DM_AGU_BOUNDS_EN.
module dm_agu
  import dm_agu_pkg::*;
#(
  parameter int AW      = 8,
  parameter int NPTR    = 4,
  parameter int PTR_RST = 0,
  parameter int LIMIT   = 2**AW,
  localparam int IW     = $clog2(NPTR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [OP_W-1:0] op,
  input  logic [IW-1:0] ptr_sel,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          adr_valid,
  input  logic          adr_ready,
  output logic [AW-1:0] dm_adr,
  output logic          dm_we,
  output logic          fault
);

  if (NPTR < 2 || (NPTR & (NPTR - 1)) != 0) begin : g_bad_nptr
    $error("dm_agu: NPTR must be a power of two >= 2");
  end
  if (LIMIT < 1) begin : g_bad_limit
    $error("dm_agu: LIMIT must be positive");
  end

  logic          r_adr_valid;
  logic [AW-1:0] r_adr;
  logic          r_we;
  logic          r_fault;

  logic          w_acc;
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] w_adr;
  logic          w_we;
  logic          w_prod;
  logic          w_bad_op;
  logic          w_oob;
  logic          w_pwe;
  logic [AW-1:0] w_pwdata;

  assign req_ready = !r_adr_valid || adr_ready;
  assign w_acc     = req_valid && req_ready;

  dm_ptr_file #(
    .AW      (AW),
    .NPTR    (NPTR),
    .PTR_RST (PTR_RST)
  ) u_ptr_file (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_acc && w_pwe),
    .i_widx  (ptr_sel),
    .i_wdata (w_pwdata),
    .i_ridx  (ptr_sel),
    .o_rdata (w_ptr)
  );

  always_comb begin
    w_adr    = '1;
    w_we     = 1'b0;
    w_prod   = 1'b0;
    w_bad_op = 1'b0;
    w_oob    = 1'b0;
    w_pwe    = 1'b0;
    w_pwdata = w_ptr + AW'(1);
    case (op_t'(op))
      kLDM: begin
        w_adr  = in_b;
        w_prod = 1'b1;
      end
      kSTR: begin
        w_adr  = in_a;
        w_we   = 1'b1;
        w_prod = 1'b1;
      end
      kLDP: begin
        w_adr  = w_ptr;
        w_prod = 1'b1;
        w_pwe  = 1'b1;
      end
      kSTP: begin
        w_adr  = w_ptr;
        w_we   = 1'b1;
        w_prod = 1'b1;
        w_pwe  = 1'b1;
      end
      kSETP: begin
        w_pwe    = 1'b1;
        w_pwdata = in_a;
      end
      default: w_bad_op = 1'b1;
    endcase
`ifdef DM_AGU_BOUNDS_EN
    // Out-of-range addresses are dropped but the post-increment still happens.
    if (w_prod && ({1'b0, w_adr} >= (AW+1)'(LIMIT))) begin
      w_prod = 1'b0;
      w_oob  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adr_valid <= 1'b0;
      r_adr       <= '0;
      r_we        <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= w_acc && (w_bad_op || w_oob);
      if (w_acc) begin
        r_adr_valid <= w_prod;
        if (w_prod) begin
          r_adr <= w_adr;
          r_we  <= w_we;
        end else if (w_bad_op) begin
          r_adr <= '1;
        end
      end else if (adr_ready) begin
        r_adr_valid <= 1'b0;
      end
    end
  end

  assign adr_valid = r_adr_valid;
  assign dm_adr    = r_adr;
  assign dm_we     = r_we;
  assign fault     = r_fault;

endmodule

// File: tb/tb_dm_agu.sv
// Directed bench for dm_agu: pointer sequencing, wrap, stall, illegal opcode,
// reset mid-stall and the bounds limit (LIMIT=8'h80 when DM_AGU_BOUNDS_EN is set).
module tb_dm_agu;

`ifdef DM_AGU_BOUNDS_EN
  localparam bit BND   = 1'b1;
  localparam int LIMIT = 'h80;
`else
  localparam bit BND   = 1'b0;
  localparam int LIMIT = 256;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] op = 3'd0;
  logic [1:0] ptr_sel = 2'd0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       adr_valid;
  logic       adr_ready = 1'b1;
  logic [7:0] dm_adr;
  logic       dm_we;
  logic       fault;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LDM = 3'd0, STR = 3'd1, LDP = 3'd2, STP = 3'd3, SETP = 3'd4;

  dm_agu #(
    .AW      (8),
    .NPTR    (4),
    .PTR_RST (0),
    .LIMIT   (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .ptr_sel   (ptr_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .adr_valid (adr_valid),
    .adr_ready (adr_ready),
    .dm_adr    (dm_adr),
    .dm_we     (dm_we),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] o, input logic [1:0] p, input logic [7:0] a,
                     input logic [7:0] b);
    req_valid = 1'b1;
    op        = o;
    ptr_sel   = p;
    in_a      = a;
    in_b      = b;
  endtask

  initial begin
    #1 reset = 1'b1;
    step();
    step();
    check("rst_adr_valid", 32'(adr_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_dm_adr", 32'(dm_adr), 0);
    check("rst_dm_we", 32'(dm_we), 0);
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 1);

    // SETP ptr2 = 0x10, then back-to-back LDP ptr2
    req(SETP, 2'd2, 8'h10, 8'h00);
    step();
    check("setp_no_access", 32'(adr_valid), 0);
    req(LDP, 2'd2, 8'h00, 8'h00);
    step();
    check("ldp0_valid", 32'(adr_valid), 1);
    check("ldp0_adr", 32'(dm_adr), 'h10);
    check("ldp0_we", 32'(dm_we), 0);
    step();
    check("ldp1_adr", 32'(dm_adr), 'h11);
    step();
    check("ldp2_adr", 32'(dm_adr), 'h12);
    step();
    check("ldp3_ptr2_13", 32'(dm_adr), 'h13);
    req_valid = 1'b0;
    step();
    check("consumed_clears", 32'(adr_valid), 0);

    // Pointer wrap through all-ones
    req(SETP, 2'd0, 8'hFF, 8'h00);
    step();
    req(STP, 2'd0, 8'h00, 8'h00);
    step();
    check("stp_ff_valid", 32'(adr_valid), BND ? 0 : 1);
    check("stp_ff_adr", 32'(dm_adr), BND ? 'h13 : 'hFF);
    check("stp_ff_we", 32'(dm_we), BND ? 0 : 1);
    check("stp_ff_fault", 32'(fault), BND ? 1 : 0);
    step();
    check("stp_wrap_valid", 32'(adr_valid), 1);
    check("stp_wrap_adr", 32'(dm_adr), 'h00);
    check("stp_wrap_we", 32'(dm_we), 1);
    check("stp_wrap_fault", 32'(fault), 0);
    req_valid = 1'b0;
    step();

    // Stall: LDM held four cycles while an LDP ptr1 waits
    adr_ready = 1'b0;
    req(LDM, 2'd0, 8'h00, 8'h03);
    step();
    check("stall_valid", 32'(adr_valid), 1);
    check("stall_adr", 32'(dm_adr), 'h03);
    check("stall_we", 32'(dm_we), 0);
    check("stall_ready", 32'(req_ready), 0);
    req(LDP, 2'd1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_adr", 32'(dm_adr), 'h03);
      check("stall_hold_valid", 32'(adr_valid), 1);
      check("stall_hold_ready", 32'(req_ready), 0);
    end
    adr_ready = 1'b1;
    step();
    check("release_ldp_adr", 32'(dm_adr), 'h00);
    check("release_ldp_valid", 32'(adr_valid), 1);
    step();
    check("release_ldp_inc", 32'(dm_adr), 'h01);
    req_valid = 1'b0;
    step();

    // Illegal opcode
    req(3'b111, 2'd0, 8'h00, 8'h00);
    step();
    check("bad_op_fault", 32'(fault), 1);
    check("bad_op_valid", 32'(adr_valid), 0);
    check("bad_op_adr", 32'(dm_adr), 'hFF);
    req_valid = 1'b0;
    step();
    check("bad_op_pulse_end", 32'(fault), 0);
    req(LDP, 2'd0, 8'h00, 8'h00);
    step();
    check("bad_op_ptr0_kept", 32'(dm_adr), 'h01);
    req_valid = 1'b0;
    step();

    // Reset while a stalled address is pending
    adr_ready = 1'b0;
    req(LDM, 2'd0, 8'h00, 8'h05);
    step();
    check("pre_rst_valid", 32'(adr_valid), 1);
    check("pre_rst_adr", 32'(dm_adr), 'h05);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(adr_valid), 0);
    check("async_rst_adr", 32'(dm_adr), 0);
    step();
    reset = 1'b0;
    check("post_rst_ready", 32'(req_ready), 1);
    step();
    check("pending_dropped", 32'(adr_valid), 0);
    adr_ready = 1'b1;
    req(LDP, 2'd0, 8'h00, 8'h00);
    step();
    check("rst_ptr0", 32'(dm_adr), 'h00);
    req(LDP, 2'd2, 8'h00, 8'h00);
    step();
    check("rst_ptr2", 32'(dm_adr), 'h00);

    // Bounds at 0x80 (checked only when enabled)
    req(STR, 2'd0, 8'h80, 8'h00);
    step();
    check("str80_valid", 32'(adr_valid), BND ? 0 : 1);
    check("str80_fault", 32'(fault), BND ? 1 : 0);
    req(STR, 2'd0, 8'h7F, 8'h00);
    step();
    check("str7f_valid", 32'(adr_valid), 1);
    check("str7f_adr", 32'(dm_adr), 'h7F);
    check("str7f_we", 32'(dm_we), 1);
    check("str7f_fault", 32'(fault), 0);
    req_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_agu.md
DM_AGU -- requirements
Module: dm_agu

Interface
REQ-001 SHALL provide parameter AW, 8, data-memory address width in bits.
REQ-002 SHALL provide parameter NPTR, 4, number of pointer registers (power of two, >=2).
REQ-003 SHALL provide parameter PTR_RST, 0, reset value loaded into every pointer register.
REQ-004 SHALL provide parameter LIMIT, 2**AW, first illegal address; used only under DM_AGU_BOUNDS_EN.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 asynchronous active-high reset.
REQ-006 SHALL have ports: req_valid input 1 request present; req_ready output 1 request accepted this cycle when high with req_valid.
REQ-007 SHALL have ports: op input 3 opcode (op_t); ptr_sel input $clog2(NPTR) pointer index; in_a input AW operand A; in_b input AW operand B.
REQ-008 SHALL have ports: adr_valid output 1 address held for data memory; adr_ready input 1 memory consumes address; dm_adr output AW address; dm_we output 1 store (1) or load (0).
REQ-009 SHALL have port fault output 1, a one-cycle pulse flagging a rejected request.

Function
REQ-010 SHALL accept a request on any rising edge where req_valid && req_ready; req_ready = !adr_valid || adr_ready (single-entry output register, full throughput).
REQ-011 SHALL present the resulting address on dm_adr with adr_valid high exactly 1 cycle after acceptance.
REQ-012 kLDM: dm_adr = in_b, dm_we = 0; pointers unchanged.
REQ-013 kSTR: dm_adr = in_a, dm_we = 0->1 (store), pointers unchanged.
REQ-014 kLDP: dm_adr = ptr[ptr_sel], dm_we = 0; ptr[ptr_sel] <= ptr[ptr_sel] + 1 at acceptance.
REQ-015 kSTP: dm_adr = ptr[ptr_sel], dm_we = 1; ptr[ptr_sel] <= ptr[ptr_sel] + 1 at acceptance.
REQ-016 kSETP: ptr[ptr_sel] <= in_a at acceptance; no memory access (adr_valid not set).
REQ-017 Any other opcode: no access, no pointer change, fault pulses 1 cycle after acceptance; dm_adr driven all-ones.
REQ-018 Pointer increment SHALL wrap modulo 2**AW (all-ones + 1 = 0) without fault.
REQ-019 While adr_valid && !adr_ready: dm_adr, dm_we, adr_valid SHALL hold stable; req_ready low; no pointer updates.
REQ-020 adr_valid SHALL clear on the cycle after consumption unless a new address-producing request is accepted the same edge (back-to-back).
REQ-021 A kLDP/kSTP immediately following kSETP on the same pointer SHALL use the newly written value (no hazard bubble).
REQ-022 When adr_valid is low, dm_adr and dm_we SHALL hold their last values (no X).

Reset
REQ-023 On reset assertion, asynchronously: adr_valid=0, fault=0, dm_adr=0, dm_we=0, all pointers=PTR_RST.
REQ-024 Reset mid-stall SHALL drop the pending address; it is never presented after reset release.
REQ-025 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 Macro DM_AGU_BOUNDS_EN defined: any computed address >= LIMIT SHALL be suppressed (no adr_valid), fault pulses, pointer post-increment still occurs.
REQ-027 Macro undefined: no bounds check; LIMIT ignored; fault only for illegal opcodes.

Structure
REQ-028 op_t enum (kLDM, kSTR, kLDP, kSTP, kSETP) and its 3-bit encodings SHALL live in the shared definitions package used by the decoder.
REQ-029 Pointer storage SHALL be sub-module dm_ptr_file (NPTR x AW, one write port, one combinational read port, write-first bypass per REQ-021).

Verification
REQ-030 kSETP ptr 2 in_a=8'h10, then kLDP ptr 2 x3 with adr_ready=1 -> dm_adr 10,11,12 on consecutive cycles, dm_we=0, ptr2 ends 8'h13.
REQ-031 kSETP ptr 0 = 8'hFF, kSTP ptr 0 twice -> dm_adr FF then 00, dm_we=1, no fault.
REQ-032 kLDM in_b=3 with adr_ready=0 for 4 cycles -> dm_adr=3 held, req_ready=0, second queued kLDP leaves pointer unchanged until release.
REQ-033 Opcode 3'b111 -> fault high 1 cycle, adr_valid stays 0, pointers unchanged.
REQ-034 Reset asserted while adr_valid=1 stalled -> adr_valid=0 immediately, all pointers = PTR_RST, req_ready=1 after release.
REQ-035 With DM_AGU_BOUNDS_EN, LIMIT=8'h80: kSTR in_a=8'h80 -> fault, no adr_valid; in_a=8'h7F -> dm_adr 7F, dm_we=1.
